// File: rtl/lbus_master.sv
// Local-bus initiator: turns single core load/store requests into one-cycle
// sel transactions on the peripheral bus and returns an extended load result.
module lbus_master #(
    parameter int          XLEN    = 32,
    parameter logic [15:0] BASE_HI = 16'hFFFF,
    parameter int          RD_LAT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            sel,
    output logic [15:0]     addr,
    output logic [2:0]      we,
    output logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata
);

    typedef enum logic [1:0] {IDLE, BUS, WAIT, RESP} state_t;

    localparam int          LANES    = XLEN / 8;
    localparam logic [1:0]  LAT_LOAD = 2'(RD_LAT - 1);

    state_t          state_reg, state_next;
    logic [1:0]      cnt_reg;
    logic [1:0]      size_reg;
    logic            unsigned_reg;
    logic            write_reg;
    logic [15:0]     addr_reg;
    logic [2:0]      we_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] rsp_rdata_reg;
    logic            rsp_err_reg;

    logic            accept;
    logic            req_err;
    logic [2:0]      req_we;
    logic [XLEN-1:0] load_data;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;
    logic [7:0]      lane_bytes [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_bytes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign accept = req_valid && req_ready;

    always_comb begin
        req_err = (req_addr[31:16] != BASE_HI)
               || (req_size == 2'd3)
               || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
        case (req_size)
            2'd0:    req_we = 3'b001;
            2'd1:    req_we = 3'b010;
            default: req_we = 3'b100;
        endcase
    end

    // Responder returns the whole aligned word; pick the lane(s) by address.
    always_comb begin
        byte_val  = lane_bytes[addr_reg[1:0]];
        half_val  = {lane_bytes[{addr_reg[1], 1'b1}], lane_bytes[{addr_reg[1], 1'b0}]};
        load_data = rdata;
        case (size_reg)
            2'd0: load_data = unsigned_reg ? {{(XLEN-8){1'b0}}, byte_val}
                                           : {{(XLEN-8){byte_val[7]}}, byte_val};
            2'd1: load_data = unsigned_reg ? {{(XLEN-16){1'b0}}, half_val}
                                           : {{(XLEN-16){half_val[15]}}, half_val};
            default: load_data = rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        sel        = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_next = req_err ? RESP : BUS;
                end
            end
            BUS: begin
                sel        = 1'b1;
                state_next = write_reg ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_reg == 2'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus-side registers only change on an accepted, legal request so that
    // addr/we/wdata hold their last values between transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg       <= 2'd0;
            size_reg      <= 2'd0;
            unsigned_reg  <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= 16'd0;
            we_reg        <= 3'd0;
            wdata_reg     <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                size_reg      <= req_size;
                unsigned_reg  <= req_unsigned;
                write_reg     <= req_write;
                rsp_err_reg   <= req_err;
                rsp_rdata_reg <= '0;
                if (!req_err) begin
                    addr_reg  <= req_addr[15:0];
                    we_reg    <= req_write ? req_we : 3'b000;
                    wdata_reg <= req_wdata;
                end
            end
            if (state_reg == BUS) begin
                cnt_reg <= LAT_LOAD;
            end else if (state_reg == WAIT && cnt_reg != 2'd0) begin
                cnt_reg <= cnt_reg - 2'd1;
            end
            if (state_reg == WAIT && cnt_reg == 2'd0) begin
                rsp_rdata_reg <= load_data;
            end
        end
    end

    assign addr      = addr_reg;
    assign we        = we_reg;
    assign wdata     = wdata_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_lbus_master.sv
// Randomised bench for lbus_master: two instances (RD_LAT 1 and 3) share the
// stimulus and are checked cycle by cycle against a behavioural model.
module tb_lbus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic [31:0] rdata;

    logic        req_ready_w [2];
    logic        rsp_valid_w [2];
    logic [31:0] rsp_rdata_w [2];
    logic        rsp_err_w   [2];
    logic        sel_w       [2];
    logic [15:0] addr_w      [2];
    logic [2:0]  we_w        [2];
    logic [31:0] wdata_w     [2];

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    lbus_master #(.XLEN(32), .BASE_HI(16'hFFFF), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_w[0]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_w[0]), .rsp_err(rsp_err_w[0]),
        .sel(sel_w[0]), .addr(addr_w[0]), .we(we_w[0]), .wdata(wdata_w[0]),
        .rdata(rdata)
    );

    lbus_master #(.XLEN(32), .BASE_HI(16'hFFFF), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_w[1]),
        .req_addr(req_addr), .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_w[1]), .rsp_err(rsp_err_w[1]),
        .sel(sel_w[1]), .addr(addr_w[1]), .we(we_w[1]), .wdata(wdata_w[1]),
        .rdata(rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int rd_lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
        if (a[31:16] != 16'hFFFF) return 1'b1;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic un, input logic [31:0] bus);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (bus >> (8 * (a % 4))) & 32'hFF;
            if (!un && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (bus >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
            if (!un && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = bus;
        end
        return v;
    endfunction

    // One transaction, cycle c counted from the accept edge. hold > 0 keeps
    // rsp_ready low until hold cycles after the slower instance responds.
    task automatic run_txn(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                           input logic un, input logic [31:0] wd, input logic [31:0] bus,
                           input int hold);
        logic        e;
        logic [2:0]  ewe;
        logic [31:0] erd;
        int          lat [2];
        int          h   [2];
        int          rc, maxh, minh;
        e   = model_err(a, sz);
        ewe = !wr ? 3'b000 : (sz == 2'd0) ? 3'b001 : (sz == 2'd1) ? 3'b010 : 3'b100;
        erd = (e || wr) ? 32'h0 : model_load(a, sz, un, bus);
        for (int i = 0; i < 2; i++) lat[i] = e ? 1 : (wr ? 2 : 2 + rd_lat(i));
        rc = (hold == 0) ? 0 : ((lat[0] > lat[1]) ? lat[0] : lat[1]) + hold;
        for (int i = 0; i < 2; i++) h[i] = (lat[i] > rc) ? lat[i] : rc;
        maxh = (h[0] > h[1]) ? h[0] : h[1];
        minh = (h[0] < h[1]) ? h[0] : h[1];
        $display("txn addr=%h wr=%0d size=%0d uns=%0d wdata=%h bus=%h hold=%0d -> err=%0d rdata=%h",
                 a, wr, sz, un, wd, bus, hold, e, erd);
        for (int i = 0; i < 2; i++) check_eq($sformatf("req_ready_pre[%0d]", i), 32'(req_ready_w[i]), 32'd1);
        req_valid = 1'b1; req_addr = a; req_write = wr; req_size = sz;
        req_unsigned = un; req_wdata = wd; rdata = bus;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_write = 1'($urandom_range(0, 1));
        req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom_range(0, 1));
        req_wdata = $urandom;
        for (int c = 1; c <= maxh + 1; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic exp_sel, exp_rv;
                exp_sel = !e && (c == 1);
                exp_rv  = (c >= lat[i]) && (c <= h[i]);
                check_eq($sformatf("sel[%0d] c%0d", i, c), 32'(sel_w[i]), 32'(exp_sel));
                if (exp_sel) begin
                    check_eq($sformatf("addr[%0d]", i), 32'(addr_w[i]), 32'(a[15:0]));
                    check_eq($sformatf("we[%0d]", i), 32'(we_w[i]), 32'(ewe));
                    if (wr) check_eq($sformatf("wdata[%0d]", i), wdata_w[i], wd);
                end
                check_eq($sformatf("rsp_valid[%0d] c%0d", i, c), 32'(rsp_valid_w[i]), 32'(exp_rv));
                if (exp_rv) begin
                    check_eq($sformatf("rsp_rdata[%0d] c%0d", i, c), rsp_rdata_w[i], erd);
                    check_eq($sformatf("rsp_err[%0d] c%0d", i, c), 32'(rsp_err_w[i]), 32'(e));
                end
                check_eq($sformatf("req_ready[%0d] c%0d", i, c), 32'(req_ready_w[i]), 32'(c > h[i]));
            end
            rsp_ready = (c >= rc);
            if (c <= minh) begin
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = {16'hFFFF, 16'($urandom)};
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic reset_during_sel();
        $display("txn reset during sel of load at ffff4000");
        req_valid = 1'b1; req_addr = 32'hFFFF_4000; req_write = 1'b0;
        req_size = 2'd2; req_unsigned = 1'b0; rdata = 32'hDEAD_BEEF; rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) check_eq($sformatf("rst_sel_before[%0d]", i), 32'(sel_w[i]), 32'd1);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("rst_sel[%0d]", i), 32'(sel_w[i]), 32'd0);
            check_eq($sformatf("rst_rsp_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'd0);
            check_eq($sformatf("rst_req_ready[%0d]", i), 32'(req_ready_w[i]), 32'd1);
            check_eq($sformatf("rst_addr[%0d]", i), 32'(addr_w[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check_eq($sformatf("post_rst_rsp_valid[%0d] c%0d", i, c), 32'(rsp_valid_w[i]), 32'd0);
                check_eq($sformatf("post_rst_sel[%0d] c%0d", i, c), 32'(sel_w[i]), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1; rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("reset_req_ready[%0d]", i), 32'(req_ready_w[i]), 32'd1);
            check_eq($sformatf("reset_rsp_valid[%0d]", i), 32'(rsp_valid_w[i]), 32'd0);
            check_eq($sformatf("reset_rsp_err[%0d]", i), 32'(rsp_err_w[i]), 32'd0);
            check_eq($sformatf("reset_rsp_rdata[%0d]", i), rsp_rdata_w[i], 32'd0);
            check_eq($sformatf("reset_sel[%0d]", i), 32'(sel_w[i]), 32'd0);
            check_eq($sformatf("reset_addr[%0d]", i), 32'(addr_w[i]), 32'd0);
            check_eq($sformatf("reset_we[%0d]", i), 32'(we_w[i]), 32'd0);
            check_eq($sformatf("reset_wdata[%0d]", i), wdata_w[i], 32'd0);
        end

        run_txn(32'hFFFF_4000, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 0);
        run_txn(32'hFFFF_4003, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80AA_BBCC, 0);
        run_txn(32'hFFFF_4003, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80AA_BBCC, 0);
        run_txn(32'hFFFF_4002, 1'b0, 2'd1, 1'b0, 32'h0, 32'h7FFE_0001, 0);
        run_txn(32'hFFFF_4005, 1'b1, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 0);
        run_txn(32'hFFFF_4006, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 0);
        run_txn(32'h0000_4000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 0);
        run_txn(32'hFFFF_4001, 1'b0, 2'd1, 1'b0, 32'h0, 32'h1111_2222, 0);
        run_txn(32'hFFFF_4002, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 0);
        run_txn(32'hFFFF_4000, 1'b0, 2'd3, 1'b0, 32'h0, 32'h1111_2222, 0);
        run_txn(32'hFFFF_4001, 1'b0, 2'd0, 1'b0, 32'h0, 32'h55AA_9A33, 5);
        run_txn(32'hFFFF_4000, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 5);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : {16'hFFFF, 16'($urandom)};
            run_txn(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        reset_during_sel();
        run_txn(32'hFFFF_4002, 1'b0, 2'd1, 1'b1, 32'h0, 32'h9ABC_0001, 0);
        run_txn(32'hFFFF_4008, 1'b1, 2'd2, 1'b0, 32'h0BAD_CAFE, 32'h0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lbus_master.md
# lbus_master

Local-bus initiator that turns single CPU load/store requests into transactions on the peripheral local bus (`sel`/`addr`/`we`/`wdata`/`rdata`), the bus that timer, UART and similar register blocks respond on. It sits between the core's memory stage and the peripheral address window. Its job is to:
- decode the peripheral window and convert access size into the bus `we` encoding;
- wait a fixed read latency and extract the addressed byte or halfword from the returned word, with sign or zero extension;
- hold the response until the core accepts it.

## Interface
Parameters:
- `XLEN`, 32, data width (taken from `core_general.vh`).
- `BASE_HI`, 16'hFFFF, required value of `req_addr[31:16]` for the peripheral window.
- `RD_LAT`, 1, cycles from the `sel` cycle to valid `rdata`; legal range 1..4.

Ports:
- `clk` input 1: global clock; all logic on the rising edge.
- `rst` input 1: global reset, asynchronous, active-high.
- `req_valid` input 1: core request valid.
- `req_ready` output 1: block can accept a request.
- `req_addr` input 32: byte address.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_unsigned` input 1: zero-extend loads when 1, sign-extend when 0.
- `req_wdata` input XLEN: store data, right-aligned.
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: core accepts the response.
- `rsp_rdata` output XLEN: load result, 0 for stores and errors.
- `rsp_err` output 1: request rejected (window miss, misaligned, or illegal size).
- `sel` output 1: bus select, one-cycle pulse.
- `addr` output 16: bus byte address, `req_addr[15:0]`.
- `we` output 3: 3'b001 byte write, 3'b010 half write, 3'b100 word write, 3'b000 read.
- `wdata` output XLEN: store data, right-aligned and unshifted; the responder lanes it by `addr[1:0]`.
- `rdata` input XLEN: full aligned word from the responder.

## Operation
- State machine states:
  - `IDLE`: `req_ready` = 1.
  - `BUS`: `sel` = 1 for exactly one cycle.
  - `WAIT`: read-latency countdown.
  - `RESP`: `rsp_valid` = 1.
- The request is captured into internal registers on `req_valid && req_ready`. Request inputs are ignored at all other times.
- Error check happens at acceptance. An error is any of:
  - `req_addr[31:16] != BASE_HI`;
  - `req_size == 3`;
  - half access with `addr[0] != 0`;
  - word access with `addr[1:0] != 0`.

  On error the state goes `IDLE` -> `RESP` with `rsp_err` = 1 and `rsp_rdata` = 0, and no bus cycle is issued.
- Store path: `IDLE` -> `BUS` -> `RESP`. `we` is taken from `req_size`; `wdata` = `req_wdata`.
- Load path: `IDLE` -> `BUS` -> `WAIT` -> `RESP`. `we` = 0. A 2-bit counter loads RD_LAT-1 in `BUS` and decrements in `WAIT`. `rdata` is sampled on the edge leaving `WAIT` when the counter is 0.
- Load extraction:
  - byte = `rdata[8*addr[1:0] +: 8]`;
  - half = `rdata[16*addr[1] +: 16]`;
  - word = `rdata`;
  - then extend to XLEN per `req_unsigned`.
- `RESP` holds `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready`, then returns to `IDLE`. There is one outstanding transaction at most; no pipelining.
- Outside `BUS`, `addr`, `we` and `wdata` hold their last values. Responders qualify them with `sel`.

## Timing
- Reset values: state `IDLE`, `req_ready` = 1, `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0, `sel` = 0, `addr` = 0, `we` = 0, `wdata` = 0, counter = 0.
- Reset asserted mid-transaction (including during `sel`) clears outputs immediately. The transaction is dropped with no response.
- Request accepted at edge T (end of cycle T):
  - `sel` is high in cycle T+1.
  - Store: `rsp_valid` is high from cycle T+2.
  - Load: `rdata` is valid in cycle T+1+RD_LAT and sampled at the end of that cycle; `rsp_valid` is high from cycle T+2+RD_LAT.
  - Error: `rsp_valid` is high from cycle T+1.
- `req_ready` is combinational from state (`IDLE` only). It is low from T+1 until the cycle after `rsp_valid && rsp_ready`.
- `rsp_ready` held high gives back-to-back throughput of one store per 3 cycles and one load per 3+RD_LAT cycles.
- `rsp_valid` falls in the cycle after the handshake. The block does not accept a new request in that same handshake cycle.

## Test plan
- Store word, `req_addr` = 32'hFFFF_4000, `req_wdata` = 32'h1234_5678 -> `sel` pulse one cycle, `addr` = 16'h4000, `we` = 3'b100, `wdata` = 32'h1234_5678; `rsp_valid` 2 cycles after accept, `rsp_err` = 0.
- Load byte signed, `req_addr` = 32'hFFFF_4003, `rdata` = 32'h80AA_BBCC, RD_LAT = 1 and 3 -> `we` = 0, `rsp_rdata` = 32'hFFFF_FF80, `rsp_valid` at T+3 and T+5 respectively. Repeat with `req_unsigned` = 1 -> 32'h0000_0080.
- Load half, `req_addr` = 32'hFFFF_4002, `rdata` = 32'h7FFE_0001 -> `rsp_rdata` = 32'h0000_7FFE.
- Errors: `req_addr` = 32'h0000_4000; half access at 16'h4001; word access at 16'h4002; `req_size` = 3 -> `sel` never asserted, `rsp_err` = 1, `rsp_rdata` = 0, `rsp_valid` at T+1.
- Backpressure: `rsp_ready` held low for 5 cycles -> `rsp_valid`, `rsp_rdata` and `rsp_err` stable; `req_ready` = 0; `req_valid` pulses ignored; after the handshake, `req_ready` = 1.
- Reset asserted during the `sel` cycle of a load -> `sel`, `rsp_valid` and `req_ready` show their reset values without waiting for `clk`; no response ever appears; the next request completes normally.
